// File: rtl/crt_sync_generator.sv
// CRT raster timing: pixel/line counters with registered, zero-latency sync and blanking decode.
// Optional FrameTick strobe is compiled in with `define CRT_SYNC_FRAME_TICK_EN.
module crt_sync_generator #(
    parameter int unsigned HDisplay    = 640,
    parameter int unsigned HFrontPorch = 16,
    parameter int unsigned HSyncPulse  = 96,
    parameter int unsigned HBackPorch  = 48,
    parameter int unsigned VDisplay    = 480,
    parameter int unsigned VFrontPorch = 10,
    parameter int unsigned VSyncPulse  = 2,
    parameter int unsigned VBackPorch  = 33,
    parameter int unsigned CounterSize = 10
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   PixelClock,
    output logic                   HSync,
    output logic                   VSync,
    output logic                   VideoOn,
    output logic [CounterSize-1:0] HCount,
    output logic [CounterSize-1:0] VCount
`ifdef CRT_SYNC_FRAME_TICK_EN
    ,
    output logic                   FrameTick
`endif
);

    localparam int unsigned HTotal     = HDisplay + HFrontPorch + HSyncPulse + HBackPorch;
    localparam int unsigned VTotal     = VDisplay + VFrontPorch + VSyncPulse + VBackPorch;
    localparam int unsigned HSyncStart = HDisplay + HFrontPorch;
    localparam int unsigned HSyncEnd   = HSyncStart + HSyncPulse;
    localparam int unsigned VSyncStart = VDisplay + VFrontPorch;
    localparam int unsigned VSyncEnd   = VSyncStart + VSyncPulse;

    localparam logic [CounterSize-1:0] HLast = CounterSize'(HTotal - 1);
    localparam logic [CounterSize-1:0] VLast = CounterSize'(VTotal - 1);
    localparam logic [CounterSize-1:0] One   = CounterSize'(1);

    logic                   pix_q;
    logic                   advance;
    logic [CounterSize-1:0] h_next;
    logic [CounterSize-1:0] v_next;
    logic                   hsync_next;
    logic                   vsync_next;
    logic                   video_next;

    // Outputs are decoded from the post-advance position so they line up with the counters.
    always_comb begin
        advance = PixelClock & ~pix_q;
        h_next  = HCount + One;
        v_next  = VCount;
        if (HCount == HLast) begin
            h_next = '0;
            if (VCount == VLast) begin
                v_next = '0;
            end else begin
                v_next = VCount + One;
            end
        end
        hsync_next = !((32'(h_next) >= HSyncStart) && (32'(h_next) < HSyncEnd));
        vsync_next = !((32'(v_next) >= VSyncStart) && (32'(v_next) < VSyncEnd));
        video_next = (32'(h_next) < HDisplay) && (32'(v_next) < VDisplay);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pix_q   <= 1'b0;
            HCount  <= '0;
            VCount  <= '0;
            HSync   <= 1'b1;
            VSync   <= 1'b1;
            VideoOn <= 1'b1;
        end else begin
            pix_q <= PixelClock;
            if (advance) begin
                HCount  <= h_next;
                VCount  <= v_next;
                HSync   <= hsync_next;
                VSync   <= vsync_next;
                VideoOn <= video_next;
            end
        end
    end

`ifdef CRT_SYNC_FRAME_TICK_EN
    localparam logic [CounterSize-1:0] VDispCount = CounterSize'(VDisplay);

    // One-cycle strobe when the raster steps onto the first blanked line.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            FrameTick <= 1'b0;
        end else begin
            FrameTick <= advance && (h_next == '0) && (v_next == VDispCount);
        end
    end
`endif

endmodule

// File: tb/tb_crt_sync_generator.sv
// Randomized bench for crt_sync_generator: a default-timing instance and a small-raster instance
// share stimulus; expectations come from an advance count mapped onto raster coordinates.
module tb_crt_sync_generator;

    logic Clock = 1'b0;
    logic Reset;
    logic PixelClock;

    logic       d_hsync, d_vsync, d_video;
    logic [9:0] d_hcount, d_vcount;
    logic       s_hsync, s_vsync, s_video;
    logic [5:0] s_hcount, s_vcount;
`ifdef CRT_SYNC_FRAME_TICK_EN
    logic       d_ft, s_ft;
`endif

    // ---------------- clock / reset
    always #4 Clock = ~Clock;

    crt_sync_generator u_def (
        .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
        .HSync(d_hsync), .VSync(d_vsync), .VideoOn(d_video),
        .HCount(d_hcount), .VCount(d_vcount)
`ifdef CRT_SYNC_FRAME_TICK_EN
        , .FrameTick(d_ft)
`endif
    );

    crt_sync_generator #(
        .HDisplay(20), .HFrontPorch(4), .HSyncPulse(6), .HBackPorch(5),
        .VDisplay(12), .VFrontPorch(3), .VSyncPulse(2), .VBackPorch(4),
        .CounterSize(6)
    ) u_sml (
        .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
        .HSync(s_hsync), .VSync(s_vsync), .VideoOn(s_video),
        .HCount(s_hcount), .VCount(s_vcount)
`ifdef CRT_SYNC_FRAME_TICK_EN
        , .FrameTick(s_ft)
`endif
    );

    // ---------------- scoreboard
    int n_vec = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    int adv       = 0;
    bit pix_prev  = 1'b0;
    bit stepped   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t adv=%0d)", tag, got, exp, $time, adv);
        end
    endtask

    // Raster position is simply the advance count folded onto the frame geometry.
    function automatic logic [23:0] expect_out(input int hd, input int hf, input int hs, input int hb,
                                               input int vd, input int vf, input int vs, input int vb,
                                               input int a, input bit st);
        int ht, vt, p, h, v;
        bit hsy, vsy, vid, ft;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        p   = a % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        hsy = !((h >= hd + hf) && (h < hd + hf + hs));
        vsy = !((v >= vd + vf) && (v < vd + vf + vs));
        vid = (h < hd) && (v < vd);
        ft  = st && (h == 0) && (v == vd);
        return {ft, vid, vsy, hsy, 10'(v), 10'(h)};
    endfunction

    task automatic compare_outputs();
        logic [23:0] e;
        e = exp_q.pop_front();
        check("def.hcount", 32'(d_hcount), 32'(e[9:0]));
        check("def.vcount", 32'(d_vcount), 32'(e[19:10]));
        check("def.hsync",  32'(d_hsync),  32'(e[20]));
        check("def.vsync",  32'(d_vsync),  32'(e[21]));
        check("def.video",  32'(d_video),  32'(e[22]));
`ifdef CRT_SYNC_FRAME_TICK_EN
        check("def.ftick",  32'(d_ft),     32'(e[23]));
`endif
        e = exp_q.pop_front();
        check("sml.hcount", 32'(s_hcount), 32'(e[9:0]));
        check("sml.vcount", 32'(s_vcount), 32'(e[19:10]));
        check("sml.hsync",  32'(s_hsync),  32'(e[20]));
        check("sml.vsync",  32'(s_vsync),  32'(e[21]));
        check("sml.video",  32'(s_video),  32'(e[22]));
`ifdef CRT_SYNC_FRAME_TICK_EN
        check("sml.ftick",  32'(s_ft),     32'(e[23]));
`endif
    endtask

    // ---------------- driver: one Clock cycle, inputs stable across the edge
    task automatic tick(input logic rst, input logic pix);
        Reset      = rst;
        PixelClock = pix;
        @(posedge Clock);
        if (rst) begin
            adv      = 0;
            pix_prev = 1'b0;
            stepped  = 1'b0;
        end else begin
            stepped  = pix && !pix_prev;
            if (stepped) adv++;
            pix_prev = pix;
        end
        exp_q.push_back(expect_out(640, 16, 96, 48, 480, 10, 2, 33, adv, stepped));
        exp_q.push_back(expect_out(20, 4, 6, 5, 12, 3, 2, 4, adv, stepped));
        #2;
        compare_outputs();
    endtask

    // ---------------- stimulus
    initial begin
        int guard;
        Reset      = 1'b1;
        PixelClock = 1'b0;

        // Reset across the first two edges, then PixelClock high one Clock in four.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        repeat (4) begin
            tick(1'b0, 1'b1);
            repeat (3) tick(1'b0, 1'b0);
        end
        check("first4.hcount", 32'(d_hcount), 32'd4);

        // A long high level is a single advance.
        repeat (10) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("hold10.hcount", 32'(d_hcount), 32'd5);

        // Random PixelClock levels.
        repeat (6000) tick(1'b0, 1'($urandom_range(0, 1)));
        // Sparse random pulses.
        repeat (4000) tick(1'b0, 1'($urandom_range(0, 3) == 0));
        // Fast alternating pulses to sweep many lines/frames.
        repeat (3000) begin
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
        end

        // Walk to a mid-frame position, then reset coincident with an advance.
        guard = 0;
        tick(1'b0, 1'b0);
        while (((adv % 735) != 261) && (guard < 2000)) begin
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
            guard++;
        end
        check("midframe.reached", 32'(guard < 2000), 32'd1);
        tick(1'b1, 1'b1);
        check("midreset.hcount", 32'(s_hcount), 32'd0);
        // PixelClock already high on the first edge after reset counts as an advance.
        tick(1'b0, 1'b1);
        check("postreset.hcount", 32'(d_hcount), 32'd1);
        repeat (5) tick(1'b0, 1'b1);

        // Reset held several cycles with PixelClock high, then more random traffic.
        repeat (3) tick(1'b1, 1'b1);
        repeat (3000) tick(1'b0, 1'($urandom_range(0, 1)));
        repeat (1500) begin
            tick(1'b0, 1'b1);
            tick(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/crt_sync_generator.md
CRT_SYNC_GENERATOR -- requirements
Module: crt_sync_generator

Interface
REQ-001 SHALL have parameter HDisplay, default 640, visible pixels per line.
REQ-002 SHALL have parameter HFrontPorch, default 16, pixels after visible region.
REQ-003 SHALL have parameter HSyncPulse, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter HBackPorch, default 48, pixels after sync pulse.
REQ-005 SHALL have parameter VDisplay, default 480, visible lines per frame.
REQ-006 SHALL have parameter VFrontPorch, default 10, lines after visible region.
REQ-007 SHALL have parameter VSyncPulse, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter VBackPorch, default 33, lines after sync pulse.
REQ-009 SHALL have parameter CounterSize, default 10, width of HCount/VCount.
REQ-010 SHALL have port Clock  input  1  system clock; all logic on its rising edge.
REQ-011 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-012 SHALL have port PixelClock  input  1  pixel-rate signal from the CRT clock divider, synchronous to Clock.
REQ-013 SHALL have port HSync  output  1  horizontal sync, active low.
REQ-014 SHALL have port VSync  output  1  vertical sync, active low.
REQ-015 SHALL have port VideoOn  output  1  high while the position is in the visible region.
REQ-016 SHALL have port HCount  output  CounterSize  current pixel column.
REQ-017 SHALL have port VCount  output  CounterSize  current line.
REQ-018 SHALL have port FrameTick  output  1  frame-update strobe; present only per REQ-032.

Function
REQ-019 SHALL register PixelClock each Clock and define an advance as PixelClock=1 while its registered copy is 0.
REQ-020 SHALL hold every output unchanged on Clock cycles without an advance; PixelClock held high for any number of cycles yields exactly one advance.
REQ-021 SHALL on an advance increment HCount; at HCount=HTotal-1 (HTotal = sum of the four H parameters, 800 by default) wrap HCount to 0 and increment VCount.
REQ-022 SHALL wrap VCount to 0 when HCount wraps with VCount=VTotal-1 (VTotal = sum of the four V parameters, 525 by default).
REQ-023 SHALL register HSync, VSync and VideoOn on the same edge as the counters, decoded from the new counter values, so outputs always match HCount/VCount with zero relative latency.
REQ-024 SHALL drive HSync=0 iff HDisplay+HFrontPorch <= HCount < HDisplay+HFrontPorch+HSyncPulse (656..751 default).
REQ-025 SHALL drive VSync=0 iff VDisplay+VFrontPorch <= VCount < VDisplay+VFrontPorch+VSyncPulse (490..491 default).
REQ-026 SHALL drive VideoOn=1 iff HCount<HDisplay and VCount<VDisplay.
REQ-027 SHALL use unsigned arithmetic; HCount/VCount never exceed HTotal-1/VTotal-1.

Reset
REQ-028 SHALL, on a Clock edge with Reset=1, set HCount=0, VCount=0, HSync=1, VSync=1, VideoOn=1, FrameTick=0, registered PixelClock=0.
REQ-029 SHALL give Reset priority over a simultaneous advance; reset mid-frame restarts at (0,0) with no partial sync pulse.
REQ-030 SHALL, when PixelClock is already high at the first Clock edge after Reset falls, count that as an advance.

Configuration
REQ-031 SHALL compile FrameTick in only when macro CRT_SYNC_FRAME_TICK_EN is defined.
REQ-032 SHALL, with CRT_SYNC_FRAME_TICK_EN, pulse FrameTick=1 for exactly one Clock cycle on the advance into (HCount=0, VCount=VDisplay), 0 otherwise; without it, port and logic are absent and all other behaviour is identical.

Verification
REQ-033 SHALL cover: Clock period 8 ns, PixelClock high 1 of every 4 Clocks, Reset 0-20 ns -> after 4 advances HCount=4, VCount=0, HSync=1, VSync=1, VideoOn=1.
REQ-034 SHALL cover: advance into HCount=640 -> VideoOn=0; into 656 -> HSync=0; into 752 -> HSync=1; advance from 799 -> HCount=0, VCount+1.
REQ-035 SHALL cover: line 479 end -> VCount=480, VideoOn=0, FrameTick high exactly one Clock (macro defined); VCount 490 and 491 -> VSync=0; advance from (799,524) -> (0,0), VideoOn=1.
REQ-036 SHALL cover: PixelClock held high 10 Clocks -> HCount advances by exactly 1.
REQ-037 SHALL cover: Reset asserted one Clock at (300,200) coincident with an advance -> next cycle HCount=0, VCount=0, HSync=1, VSync=1.
REQ-038 SHALL cover: build without CRT_SYNC_FRAME_TICK_EN -> no FrameTick port; REQ-033..037 sync/count results identical.
